// File: rtl/vga_timing_gen_if.sv
// Scan-position, renderer colour and VGA pin bundle
// shared by the timing generator and its consumers.
interface vga_timing_gen_if;
  logic       R_in;
  logic       G_in;
  logic       B_in;
  logic [9:0] CounterX;
  logic [9:0] CounterY;
  logic       inDisplayArea;
  logic       PixelTick;
  logic       FrameTick;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic       vga_r;
  logic       vga_g;
  logic       vga_b;

  modport master (
    input  R_in, G_in, B_in,
    output CounterX, CounterY,
    output inDisplayArea,
    output PixelTick, FrameTick,
    output vga_h_sync, vga_v_sync,
    output vga_r, vga_g, vga_b
  );

  modport slave (
    output R_in, G_in, B_in,
    input  CounterX, CounterY,
    input  inDisplayArea,
    input  PixelTick, FrameTick,
    input  vga_h_sync, vga_v_sync,
    input  vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing with a registered
// output stage aligning syncs and colour.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic        Clk,
  input logic        Reset_n,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI =
    10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI =
    10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic          x_last;
  logic          y_last;
  logic          h_pulse;
  logic          v_pulse;

  assign x_last = (bus.CounterX == X_LAST);
  assign y_last = (bus.CounterY == Y_LAST);

  assign bus.inDisplayArea =
    (bus.CounterX < 10'(H_ACTIVE)) &&
    (bus.CounterY < 10'(V_ACTIVE));

  assign h_pulse = (bus.CounterX >= HS_LO) &&
                   (bus.CounterX <  HS_HI);
  assign v_pulse = (bus.CounterY >= VS_LO) &&
                   (bus.CounterY <  VS_HI);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div           <= '0;
      bus.PixelTick <= 1'b0;
    end else begin
      div           <= (div == DIV_LAST) ? '0
                       : div + 1'b1;
      bus.PixelTick <= (div == DIV_LAST);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.CounterX  <= '0;
      bus.CounterY  <= '0;
      bus.FrameTick <= 1'b0;
    end else begin
      bus.FrameTick <= bus.PixelTick &&
                       x_last && y_last;
      if (bus.PixelTick) begin
        if (x_last) begin
          bus.CounterX <= '0;
          bus.CounterY <= y_last ? '0
                          : bus.CounterY + 10'd1;
        end else begin
          bus.CounterX <= bus.CounterX + 10'd1;
        end
      end
    end
  end

  // Pins lag the scan position by one pixel period.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.vga_h_sync <= 1'b1;
      bus.vga_v_sync <= 1'b1;
      bus.vga_r      <= 1'b0;
      bus.vga_g      <= 1'b0;
      bus.vga_b      <= 1'b0;
    end else if (bus.PixelTick) begin
      bus.vga_h_sync <= ~h_pulse;
      bus.vga_v_sync <= ~v_pulse;
      bus.vga_r      <= bus.R_in & bus.inDisplayArea;
      bus.vga_g      <= bus.G_in & bus.inDisplayArea;
      bus.vga_b      <= bus.B_in & bus.inDisplayArea;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a
// reduced raster and a position-arithmetic model.
module tb_vga_timing_gen;

  localparam int D  = 2;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n = 0;
  int   errors = 0;
  int   checks = 0;
  logic [2:0] col [FT];

  vga_timing_gen_if bus0 ();
  vga_timing_gen_if bus1 ();

  vga_timing_gen #(
    .CLK_DIV(D),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus0));

  vga_timing_gen #(
    .CLK_DIV(1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut1 (.Clk(clk), .Reset_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  logic [27:0] got;
  assign got = {bus0.CounterX, bus0.CounterY,
                bus0.inDisplayArea, bus0.PixelTick,
                bus0.FrameTick, bus0.vga_h_sync,
                bus0.vga_v_sync, bus0.vga_r,
                bus0.vga_g, bus0.vga_b};

  // Pixels completed after n clock edges since release.
  function automatic int pos(int k, int d);
    return (k == 0) ? 0 : (k - 1) / d;
  endfunction

  function automatic logic disp(int x, int y);
    return (x < HA) && (y < VA);
  endfunction

  function automatic logic [27:0] exp_vec(int k);
    int p, x, y, q, qx, qy;
    logic pt, ft, h, v;
    logic [2:0] c;
    p  = pos(k, D);
    x  = p % HT;
    y  = (p / HT) % VT;
    pt = (k >= D) && (k % D == 0);
    ft = (k > D) && ((k - 1) % D == 0) && (p % FT == 0);
    if (p == 0) begin
      h = 1'b1; v = 1'b1; c = 3'b000;
    end else begin
      q  = p - 1;
      qx = q % HT;
      qy = (q / HT) % VT;
      h  = !(qx >= HA + HF && qx < HA + HF + HS);
      v  = !(qy >= VA + VF && qy < VA + VF + VS);
      c  = col[q % FT] & {3{disp(qx, qy)}};
    end
    return {10'(x), 10'(y), disp(x, y), pt, ft, h, v, c};
  endfunction

  task automatic drive();
    logic [2:0] c;
    c = col[pos(n, D) % FT];
    {bus0.R_in, bus0.G_in, bus0.B_in} = c;
    {bus1.R_in, bus1.G_in, bus1.B_in} = 3'b101;
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst_n) n++;
    #1 drive();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [27:0] e;
    rst_n = 1'b0;
    n = 0;
    drive();
    for (int i = 0; i < 10; i++) adv();
    e = exp_vec(0);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_vec got=%h exp=%h", got, e);
    end
    checks++;
    if (bus0.inDisplayArea !== 1'b1) begin
      errors++;
      $display("FAIL reset_disp got=%b exp=1",
               bus0.inDisplayArea);
    end
    checks++;
    if (bus1.PixelTick !== 1'b0 ||
        bus1.CounterX !== 10'd0) begin
      errors++;
      $display("FAIL reset_dut1 got=%b/%0d exp=0/0",
               bus1.PixelTick, bus1.CounterX);
    end
  endtask

  task automatic test_pixel_rate();
    logic [27:0] e;
    int ex1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      adv();
      e = exp_vec(n);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rate_vec n=%0d got=%h exp=%h",
                 n, got, e);
      end
      ex1 = pos(n, 1) % HT;
      checks++;
      if (bus1.PixelTick !== 1'b1 ||
          bus1.CounterX !== 10'(ex1)) begin
        errors++;
        $display("FAIL rate_div1 got=%b/%0d exp=1/%0d",
                 bus1.PixelTick, bus1.CounterX, ex1);
      end
    end
  endtask

  task automatic test_line();
    int wraps = 0;
    int prev_y;
    for (int i = 0; i < 3 * HT * D; i++) begin
      prev_y = bus0.CounterY;
      adv();
      if (bus0.PixelTick === 1'b0 &&
          bus0.CounterX === 10'd0 &&
          (n - 1) % D == 0) begin
        wraps++;
        checks++;
        if (bus0.CounterY !== 10'((prev_y + 1) % VT))
        begin
          errors++;
          $display("FAIL line_wrap got=%0d exp=%0d",
                   bus0.CounterY, (prev_y + 1) % VT);
        end
      end
    end
    checks++;
    if (wraps < 2) begin
      errors++;
      $display("FAIL line_wrap_seen got=%0d exp>=2",
               wraps);
    end
  endtask

  task automatic test_frame();
    logic [27:0] e;
    int hlow = 0, vlow = 0, fts = 0;
    int ft_first = -1, ft_period = -1;
    int start = 2 * FT * D + 1;
    while (n < start + FT * D + 5) begin
      adv();
      e = exp_vec(n);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL frame_vec n=%0d got=%h exp=%h",
                 n, got, e);
      end
      if (bus0.FrameTick === 1'b1) begin
        if (ft_first < 0) ft_first = n;
        else if (ft_period < 0) ft_period = n - ft_first;
      end
      if (n >= start && n < start + FT * D) begin
        hlow += (bus0.vga_h_sync === 1'b0) ? 1 : 0;
        vlow += (bus0.vga_v_sync === 1'b0) ? 1 : 0;
        fts  += (bus0.FrameTick === 1'b1) ? 1 : 0;
      end
    end
    checks++;
    if (vlow != VS * HT * D) begin
      errors++;
      $display("FAIL vsync_len got=%0d exp=%0d",
               vlow, VS * HT * D);
    end
    checks++;
    if (hlow != HS * VT * D) begin
      errors++;
      $display("FAIL hsync_len got=%0d exp=%0d",
               hlow, HS * VT * D);
    end
    checks++;
    if (fts != 1) begin
      errors++;
      $display("FAIL ftick_count got=%0d exp=1", fts);
    end
    checks++;
    if (ft_period != FT * D) begin
      errors++;
      $display("FAIL ftick_period got=%0d exp=%0d",
               ft_period, FT * D);
    end
  endtask

  task automatic test_colour();
    logic [27:0] e;
    int q, ones = 0, zeros_h = 0, zeros_v = 0;
    for (int i = 0; i < FT; i++) col[i] = 3'b111;
    drive();
    for (int i = 0; i < FT * D + 4; i++) begin
      adv();
      e = exp_vec(n);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL colour_vec n=%0d got=%h exp=%h",
                 n, got, e);
      end
      q = pos(n, D) - 1;
      if (q % HT == HA + 2 && bus0.vga_r === 1'b0)
        zeros_h++;
      if ((q / HT) % VT == VA + 2 && bus0.vga_g === 1'b0)
        zeros_v++;
      if (disp(q % HT, (q / HT) % VT) &&
          {bus0.vga_r, bus0.vga_g, bus0.vga_b} === 3'b111)
        ones++;
    end
    checks++;
    if (zeros_h == 0 || zeros_v == 0) begin
      errors++;
      $display("FAIL colour_blank got=%0d/%0d exp>0",
               zeros_h, zeros_v);
    end
    checks++;
    if (ones < HA * VA * D) begin
      errors++;
      $display("FAIL colour_on got=%0d exp>=%0d",
               ones, HA * VA * D);
    end
  endtask

  task automatic test_reset_mid();
    logic [27:0] e;
    int tgt, guard = 0;
    for (int i = 0; i < FT; i++) col[i] = 3'($urandom);
    drive();
    tgt = 5 * HT + 12 + $urandom_range(0, 3);
    while ((pos(n, D) % FT != tgt ||
            (n - 1) % D != 0) && guard < 4 * FT * D) begin
      adv();
      guard++;
    end
    checks++;
    if (bus0.CounterX !== 10'(tgt % HT)) begin
      errors++;
      $display("FAIL mid_reach got=%0d exp=%0d",
               bus0.CounterX, tgt % HT);
    end
    rst_n = 1'b0;
    n = 0;
    #1 drive();
    e = exp_vec(0);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL mid_async got=%h exp=%h", got, e);
    end
    for (int i = 0; i < 3; i++) begin
      adv();
      checks++;
      if (bus0.FrameTick !== 1'b0 || got !== e) begin
        errors++;
        $display("FAIL mid_hold got=%h exp=%h", got, e);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3 * HT * D; i++) begin
      adv();
      e = exp_vec(n);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_restart n=%0d got=%h exp=%h",
                 n, got, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < FT; i++) col[i] = 3'($urandom);
    drive();
    @(negedge clk);
    test_reset();
    test_pixel_rate();
    test_line();
    test_frame();
    test_colour();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
